autoseller_arbiter: RTL and testbench
=====================================

// Module: autoseller_arbiter
// PURPOSE
//  Shares one autoseller vending datapath between NUM_REQ kiosk front-ends.
//  Round-robin arbitration; issues one-cycle enable/money/type to the seller when ready;
//  tracks the single in-flight owner; routes change/drink back to the owner.
//  Timeout watchdog refunds a kiosk if the seller never answers.
// PARAMETERS
//  NUM_REQ   4    number of kiosk requesters (2..8)
//  TIMEOUT   64   cycles in WAIT before refund-with-error (>=2)
// PORTS
//  clk            in   1          system clock, all logic on rising edge
//  reset          in   1          synchronous, active-high reset
//  req_valid_i    in   NUM_REQ    kiosk k has a purchase pending
//  req_money_i    in   6*NUM_REQ  money of kiosk k in bits [6k+5:6k]
//  req_type_i     in   2*NUM_REQ  drink type of kiosk k in bits [2k+1:2k]
//  req_ack_o      out  NUM_REQ    one-hot 1-cycle pulse: request of kiosk k taken
//  rsp_valid_o    out  NUM_REQ    one-hot 1-cycle pulse: response for kiosk k
//  rsp_change_o   out  6          change for the responding kiosk
//  rsp_drink_o    out  2          drink delivered (2'b00 on error)
//  rsp_err_o      out  1          1 = timeout refund, qualified by rsp_valid_o
//  sell_ready_i   in   1          seller ready_o
//  sell_enable_o  out  1          seller enable_i, 1-cycle pulse
//  sell_money_o   out  6          seller money_i, 0 when sell_enable_o=0
//  sell_type_o    out  2          seller drinktype_i, 0 when sell_enable_o=0
//  sell_enable_i  in   1          seller enable_o (result valid)
//  sell_change_i  in   6          seller change_o
//  sell_drink_i   in   2          seller drink_o
//  stray_o        out  1          1-cycle pulse: seller result with no owner, dropped
// BEHAVIOUR
//  Reset: state IDLE, all outputs 0, rr pointer 0, timer 0, owner regs 0.
//  FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE; one transaction in flight, max.
//  IDLE: if sell_ready_i=1 and |req_valid_i, winner = first valid at/after rr pointer
//    (wrapping NUM_REQ-1 -> 0); latch owner index, money, type; pointer <= winner+1 (wraps);
//    go ISSUE. Else stay. No grant while sell_ready_i=0.
//  ISSUE (1 cycle): sell_enable_o=1 with latched money/type; req_ack_o[owner]=1 same cycle;
//    timer cleared; -> WAIT.
//  WAIT: timer increments each cycle. sell_enable_i=1 -> latch change/drink, err=0, -> RESP.
//    Else timer reaching TIMEOUT-1 -> change=latched money, drink=2'b00, err=1, -> RESP.
//    sell_enable_i and timeout same cycle: seller result wins, err=0.
//  RESP (1 cycle): rsp_valid_o[owner]=1, rsp_change_o/drink_o/err_o driven; -> IDLE.
//    rsp_* data are 0 whenever rsp_valid_o=0.
//  Grant-to-issue latency 1 cycle; seller result to rsp_valid_o latency 1 cycle.
//  sell_enable_i in IDLE, ISSUE or RESP (incl. late answer after timeout): ignored,
//    stray_o=1 next cycle; no state change.
//  Requester holds valid/money/type until ack; payload is sampled in the IDLE grant
//    cycle only, so changes after grant do not affect the issued transaction.
//  Dropping req_valid_i before grant withdraws the request; no ack.
//  Reset mid-transaction: abort immediately, no response pulse to owner.
//  Money/change 6-bit unsigned, passed through unmodified; no arithmetic in block.
// STRUCTURE
//  autoseller_pkg: MONEY_W=6, DRINK_W=2, state enum {IDLE,ISSUE,WAIT,RESP},
//    DRINK_NONE=2'b00.
//  Sub-module rr_arbiter: NUM_REQ req vector + pointer in, one-hot grant + index out,
//    combinational. Top holds FSM, timer ($clog2(TIMEOUT) bits), owner/data regs.
// TESTING
//  Reset, no requests, ready=1 for 20 cycles -> all outputs 0, no sell_enable_o.
//  Kiosk1 money=0x20 type=01; seller answers 3 cycles after enable, change=0x05, drink=01
//    -> sell_enable_o with 0x20/01, req_ack_o=0010, then rsp_valid_o=0010, 0x05/01, err=0.
//  All 4 kiosks valid continuously, seller ready and answering -> grant order 0,1,2,3,0.
//  No seller answer, TIMEOUT=64 -> rsp_valid_o[owner] 64 cycles after enable, change=money,
//    drink=00, err=1; later seller answer -> stray_o pulse, no rsp_valid_o.
//  sell_enable_i on the timeout cycle -> seller data returned, err=0.
//  sell_ready_i=0 with kiosks valid -> no grant; reset asserted in WAIT -> no rsp, back to IDLE.

Source files
------------

// File: rtl/autoseller_pkg.sv
// Shared widths, drink encoding and FSM state type for the autoseller arbiter.
package autoseller_pkg;
  localparam int MONEY_W = 6;
  localparam int DRINK_W = 2;
  localparam logic [DRINK_W-1:0] DRINK_NONE = 2'b00;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
endpackage

// File: rtl/autoseller_arbiter_rr.sv
// Combinational round-robin picker: first asserted request at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);
  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((int'(ptr_i) + i) % NUM_REQ);
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/autoseller_arbiter.sv
// Shares one autoseller datapath among NUM_REQ kiosks: round-robin grant, single
// in-flight owner, response routing and a timeout refund watchdog.
module autoseller_arbiter
  import autoseller_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [MONEY_W*NUM_REQ-1:0] req_money_i,
  input  logic [DRINK_W*NUM_REQ-1:0] req_type_i,
  output logic [NUM_REQ-1:0]         req_ack_o,
  output logic [NUM_REQ-1:0]         rsp_valid_o,
  output logic [MONEY_W-1:0]         rsp_change_o,
  output logic [DRINK_W-1:0]         rsp_drink_o,
  output logic                       rsp_err_o,
  input  logic                       sell_ready_i,
  output logic                       sell_enable_o,
  output logic [MONEY_W-1:0]         sell_money_o,
  output logic [DRINK_W-1:0]         sell_type_o,
  input  logic                       sell_enable_i,
  input  logic [MONEY_W-1:0]         sell_change_i,
  input  logic [DRINK_W-1:0]         sell_drink_i,
  output logic                       stray_o
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TMR_W = $clog2(TIMEOUT);
  // WAIT lasts TIMEOUT-1 cycles so the refund appears TIMEOUT cycles after the issue pulse.
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 2);

  state_t               state_q;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     owner_q;
  logic [NUM_REQ-1:0]   owner_oh;
  logic [MONEY_W-1:0]   money_q;
  logic [TMR_W-1:0]     timer_q;

  logic [NUM_REQ-1:0]   ack_q;
  logic                 sell_en_q;
  logic [MONEY_W-1:0]   sell_money_q;
  logic [DRINK_W-1:0]   sell_type_q;
  logic [NUM_REQ-1:0]   rsp_valid_q;
  logic [MONEY_W-1:0]   rsp_change_q;
  logic [DRINK_W-1:0]   rsp_drink_q;
  logic                 rsp_err_q;
  logic                 stray_q;

  logic [NUM_REQ-1:0]   gnt_vec;
  logic [IDX_W-1:0]     gnt_idx;
  logic                 gnt_any;
  logic [MONEY_W-1:0]   gnt_money;
  logic [DRINK_W-1:0]   gnt_type;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req_i (req_valid_i),
    .ptr_i (ptr_q),
    .gnt_o (gnt_vec),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  assign gnt_money = req_money_i[int'(gnt_idx) * MONEY_W +: MONEY_W];
  assign gnt_type  = req_type_i[int'(gnt_idx) * DRINK_W +: DRINK_W];
  assign ptr_d     = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
  assign owner_oh  = NUM_REQ'(1) << owner_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      owner_q      <= '0;
      money_q      <= '0;
      timer_q      <= '0;
      ack_q        <= '0;
      sell_en_q    <= 1'b0;
      sell_money_q <= '0;
      sell_type_q  <= '0;
      rsp_valid_q  <= '0;
      rsp_change_q <= '0;
      rsp_drink_q  <= DRINK_NONE;
      rsp_err_q    <= 1'b0;
      stray_q      <= 1'b0;
    end else begin
      // Pulse outputs default low; data outputs read zero while not qualified.
      ack_q        <= '0;
      sell_en_q    <= 1'b0;
      sell_money_q <= '0;
      sell_type_q  <= '0;
      rsp_valid_q  <= '0;
      rsp_change_q <= '0;
      rsp_drink_q  <= DRINK_NONE;
      rsp_err_q    <= 1'b0;
      stray_q      <= sell_enable_i && (state_q != WAIT);

      case (state_q)
        IDLE: begin
          if (sell_ready_i && gnt_any) begin
            owner_q      <= gnt_idx;
            money_q      <= gnt_money;
            ptr_q        <= ptr_d;
            ack_q        <= gnt_vec;
            sell_en_q    <= 1'b1;
            sell_money_q <= gnt_money;
            sell_type_q  <= gnt_type;
            state_q      <= ISSUE;
          end
        end
        ISSUE: begin
          timer_q <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (sell_enable_i) begin
            rsp_valid_q  <= owner_oh;
            rsp_change_q <= sell_change_i;
            rsp_drink_q  <= sell_drink_i;
            state_q      <= RESP;
          end else if (timer_q == TMR_LAST) begin
            rsp_valid_q  <= owner_oh;
            rsp_change_q <= money_q;
            rsp_err_q    <= 1'b1;
            state_q      <= RESP;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ack_o     = ack_q;
  assign sell_enable_o = sell_en_q;
  assign sell_money_o  = sell_money_q;
  assign sell_type_o   = sell_type_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_change_o  = rsp_change_q;
  assign rsp_drink_o   = rsp_drink_q;
  assign rsp_err_o     = rsp_err_q;
  assign stray_o       = stray_q;
endmodule

// File: tb/tb_autoseller_arbiter.sv
// Directed bench for autoseller_arbiter with a timestamp-based transaction model checked every cycle.
module tb_autoseller_arbiter;
  localparam int N  = 4;
  localparam int TO = 64;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid_i;
  logic [6*N-1:0] req_money_i;
  logic [2*N-1:0] req_type_i;
  logic [N-1:0]   req_ack_o, rsp_valid_o;
  logic [5:0]     rsp_change_o;
  logic [1:0]     rsp_drink_o;
  logic           rsp_err_o;
  logic           sell_ready_i;
  logic           sell_enable_o;
  logic [5:0]     sell_money_o;
  logic [1:0]     sell_type_o;
  logic           sell_enable_i = 1'b0;
  logic [5:0]     sell_change_i = '0;
  logic [1:0]     sell_drink_i  = '0;
  logic           stray_o;

  autoseller_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid_i   (req_valid_i),
    .req_money_i   (req_money_i),
    .req_type_i    (req_type_i),
    .req_ack_o     (req_ack_o),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_change_o  (rsp_change_o),
    .rsp_drink_o   (rsp_drink_o),
    .rsp_err_o     (rsp_err_o),
    .sell_ready_i  (sell_ready_i),
    .sell_enable_o (sell_enable_o),
    .sell_money_o  (sell_money_o),
    .sell_type_o   (sell_type_o),
    .sell_enable_i (sell_enable_i),
    .sell_change_i (sell_change_i),
    .sell_drink_i  (sell_drink_i),
    .stray_o       (stray_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Expected outputs for the current cycle and abstract model state.
  logic [N-1:0] e_ack = '0, e_rv = '0;
  logic         e_en = 1'b0, e_err = 1'b0, e_stray = 1'b0;
  logic [5:0]   e_money = '0, e_chg = '0;
  logic [1:0]   e_type = '0, e_drk = '0;
  bit           m_on = 1'b0, m_busy = 1'b0;
  bit           ph_issue, ph_wait, ph_resp, found;
  int           m_own = 0, m_tissue = -1, m_tresp = -1, m_ptr = 0, win = 0, w = 0;
  logic [5:0]   m_money = '0;
  int           cyc = 0;

  // Observations of the DUT used by the directed literal checks.
  int         ack_cnt = 0, en_cnt = 0, rsp_cnt = 0, stray_cnt = 0;
  int         last_en_cyc = 0, last_rsp_cyc = 0;
  logic [5:0] last_en_money = '0, last_chg = '0;
  logic [1:0] last_en_type = '0, last_drk = '0;
  logic [N-1:0] last_ack = '0, last_rv = '0;
  logic       last_err = 1'b0;
  int         ack_log[$];

  always @(negedge clk) begin
    if (m_on) begin
      chk("req_ack_o",     32'(req_ack_o),     32'(e_ack));
      chk("sell_enable_o", 32'(sell_enable_o), 32'(e_en));
      chk("sell_money_o",  32'(sell_money_o),  32'(e_money));
      chk("sell_type_o",   32'(sell_type_o),   32'(e_type));
      chk("rsp_valid_o",   32'(rsp_valid_o),   32'(e_rv));
      chk("rsp_change_o",  32'(rsp_change_o),  32'(e_chg));
      chk("rsp_drink_o",   32'(rsp_drink_o),   32'(e_drk));
      chk("rsp_err_o",     32'(rsp_err_o),     32'(e_err));
      chk("stray_o",       32'(stray_o),       32'(e_stray));
    end
    if (sell_enable_o === 1'b1) begin
      en_cnt++; last_en_cyc = cyc; last_en_money = sell_money_o; last_en_type = sell_type_o;
    end
    if (|req_ack_o === 1'b1) begin
      ack_cnt++; last_ack = req_ack_o;
      for (int k = 0; k < N; k++) if (req_ack_o[k]) ack_log.push_back(k);
    end
    if (|rsp_valid_o === 1'b1) begin
      rsp_cnt++; last_rsp_cyc = cyc; last_rv = rsp_valid_o;
      last_chg = rsp_change_o; last_drk = rsp_drink_o; last_err = rsp_err_o;
    end
    if (stray_o === 1'b1) stray_cnt++;

    // Predict next cycle's outputs from this cycle's inputs.
    e_ack = '0; e_rv = '0; e_en = 1'b0; e_money = '0; e_type = '0;
    e_chg = '0; e_drk = '0; e_err = 1'b0; e_stray = 1'b0;
    if (reset === 1'b1) begin
      m_on = 1'b1; m_busy = 1'b0; m_ptr = 0;
    end else if (m_on) begin
      ph_issue = m_busy && (cyc == m_tissue);
      ph_resp  = m_busy && (cyc == m_tresp);
      ph_wait  = m_busy && !ph_issue && !ph_resp;
      e_stray  = sell_enable_i && !ph_wait;
      if (!m_busy) begin
        if (sell_ready_i) begin
          found = 1'b0;
          for (int k = 0; k < N; k++) begin
            w = (m_ptr + k) % N;
            if (!found && req_valid_i[w]) begin found = 1'b1; win = w; end
          end
          if (found) begin
            e_ack[win] = 1'b1; e_en = 1'b1;
            e_money = req_money_i[win*6 +: 6]; e_type = req_type_i[win*2 +: 2];
            m_busy = 1'b1; m_own = win; m_money = e_money;
            m_tissue = cyc + 1; m_tresp = -1; m_ptr = (win + 1) % N;
          end
        end
      end else if (ph_wait) begin
        if (sell_enable_i) begin
          e_rv[m_own] = 1'b1; e_chg = sell_change_i; e_drk = sell_drink_i; m_tresp = cyc + 1;
        end else if (cyc == m_tissue + TO - 1) begin
          e_rv[m_own] = 1'b1; e_chg = m_money; e_drk = 2'b00; e_err = 1'b1; m_tresp = cyc + 1;
        end
      end else if (ph_resp) begin
        m_busy = 1'b0;
      end
    end
    cyc++;
  end

  // Seller responder: answers ans_delay cycles after each enable, or on demand.
  int         ans_delay = 0, countdown = 0;
  logic [5:0] ans_chg = '0;
  logic [1:0] ans_drk = '0;
  bit         manual_pulse = 1'b0;

  always begin
    @(posedge clk); #2;
    sell_enable_i = 1'b0; sell_change_i = '0; sell_drink_i = '0;
    if (countdown > 0) begin
      countdown--;
      if (countdown == 0) begin
        sell_enable_i = 1'b1; sell_change_i = ans_chg; sell_drink_i = ans_drk;
      end
    end
    if (manual_pulse) begin
      manual_pulse = 1'b0; sell_enable_i = 1'b1; sell_change_i = 6'h2A; sell_drink_i = 2'b10;
    end
    if (sell_enable_o === 1'b1 && ans_delay > 0) countdown = ans_delay;
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set_req(input int k, input logic [5:0] money, input logic [1:0] typ);
    req_money_i[k*6 +: 6] = money;
    req_type_i[k*2 +: 2]  = typ;
    req_valid_i[k]        = 1'b1;
  endtask

  task automatic wait_ack(input int max_cyc);
    int start, n;
    start = ack_cnt; n = 0;
    while (ack_cnt == start && n < max_cyc) begin tick(1); n++; end
    chk("ack_within_budget", 32'(ack_cnt != start), 32'(1));
  endtask

  task automatic wait_rsp(input int max_cyc);
    int start, n;
    start = rsp_cnt; n = 0;
    while (rsp_cnt == start && n < max_cyc) begin tick(1); n++; end
    chk("rsp_within_budget", 32'(rsp_cnt != start), 32'(1));
  endtask

  int exp_order[5] = '{0, 1, 2, 3, 0};
  int base_a, base_r, base_s, n;

  initial begin
    reset = 1'b1; req_valid_i = '0; req_money_i = '0; req_type_i = '0; sell_ready_i = 1'b0;
    tick(3);
    reset = 1'b0; sell_ready_i = 1'b1;

    // Idle with seller ready and no requests.
    tick(20);
    chk("idle_no_enable", 32'(en_cnt), 32'(0));
    chk("idle_no_ack",    32'(ack_cnt), 32'(0));
    chk("idle_no_rsp",    32'(rsp_cnt), 32'(0));
    chk("idle_no_stray",  32'(stray_cnt), 32'(0));

    // Kiosk 1 purchase, seller answers 3 cycles after enable.
    ans_delay = 3; ans_chg = 6'h05; ans_drk = 2'b01;
    set_req(1, 6'h20, 2'b01);
    wait_ack(10);
    req_valid_i = '0;
    wait_rsp(20);
    tick(2);
    chk("k1_sell_money", 32'(last_en_money), 32'h20);
    chk("k1_sell_type",  32'(last_en_type),  32'h1);
    chk("k1_ack",        32'(last_ack),      32'b0010);
    chk("k1_rsp_valid",  32'(last_rv),       32'b0010);
    chk("k1_change",     32'(last_chg),      32'h05);
    chk("k1_drink",      32'(last_drk),      32'h1);
    chk("k1_err",        32'(last_err),      32'h0);
    chk("k1_latency",    32'(last_rsp_cyc - last_en_cyc), 32'(4));

    // All kiosks valid continuously from a fresh pointer.
    reset = 1'b1; tick(2); reset = 1'b0;
    ans_delay = 2; ans_chg = 6'h01; ans_drk = 2'b11;
    ack_log.delete();
    for (int k = 0; k < N; k++) set_req(k, 6'(6'h10 + k), 2'(k));
    n = 0;
    while (ack_log.size() < 5 && n < 200) begin tick(1); n++; end
    req_valid_i = '0;
    tick(10);
    chk("rr_five_grants", 32'(ack_log.size() >= 5), 32'(1));
    for (int i = 0; i < 5; i++)
      chk("rr_order", 32'((i < ack_log.size()) ? ack_log[i] : -1), 32'(exp_order[i]));

    // Seller never answers: refund with error after TIMEOUT cycles, then a late answer.
    ans_delay = 0;
    set_req(2, 6'h3F, 2'b10);
    wait_ack(10);
    req_valid_i = '0;
    wait_rsp(80);
    tick(2);
    chk("to_latency",   32'(last_rsp_cyc - last_en_cyc), 32'(64));
    chk("to_rsp_valid", 32'(last_rv),  32'b0100);
    chk("to_change",    32'(last_chg), 32'h3F);
    chk("to_drink",     32'(last_drk), 32'h0);
    chk("to_err",       32'(last_err), 32'h1);
    base_r = rsp_cnt; base_s = stray_cnt;
    manual_pulse = 1'b1;
    tick(4);
    chk("late_stray",  32'(stray_cnt - base_s), 32'(1));
    chk("late_no_rsp", 32'(rsp_cnt - base_r),   32'(0));

    // Seller answers on the very cycle the timeout would fire.
    ans_delay = 63; ans_chg = 6'h07; ans_drk = 2'b11;
    set_req(3, 6'h11, 2'b11);
    wait_ack(10);
    req_valid_i = '0;
    wait_rsp(80);
    tick(2);
    ans_delay = 0;
    chk("edge_latency",   32'(last_rsp_cyc - last_en_cyc), 32'(64));
    chk("edge_rsp_valid", 32'(last_rv),  32'b1000);
    chk("edge_change",    32'(last_chg), 32'h07);
    chk("edge_drink",     32'(last_drk), 32'h3);
    chk("edge_err",       32'(last_err), 32'h0);

    // Seller not ready: no grant; withdrawn request is never acked.
    sell_ready_i = 1'b0; base_a = ack_cnt;
    set_req(0, 6'h0C, 2'b01);
    tick(10);
    chk("not_ready_no_ack", 32'(ack_cnt - base_a), 32'(0));
    req_valid_i = '0;
    tick(1);
    sell_ready_i = 1'b1;
    tick(5);
    chk("withdrawn_no_ack", 32'(ack_cnt - base_a), 32'(0));

    // Reset while waiting on the seller aborts silently.
    set_req(0, 6'h0C, 2'b01);
    wait_ack(10);
    req_valid_i = '0;
    tick(5);
    base_r = rsp_cnt;
    reset = 1'b1; tick(1); reset = 1'b0;
    tick(70);
    chk("reset_abort_no_rsp", 32'(rsp_cnt - base_r), 32'(0));

    // A fresh transaction after the abort completes normally.
    ans_delay = 1; ans_chg = 6'h15; ans_drk = 2'b10;
    set_req(1, 6'h33, 2'b10);
    wait_ack(10);
    req_valid_i = '0;
    wait_rsp(20);
    tick(2);
    chk("post_reset_rsp_valid", 32'(last_rv),  32'b0010);
    chk("post_reset_change",    32'(last_chg), 32'h15);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end
endmodule
